// File: rtl/tl_ul_initiator.sv
// TL-UL initiator: turns a simple core request/response handshake into A/D channel beats,
// tracking up to 2**TL_RS outstanding transactions by source ID.
module tl_ul_initiator #(
  parameter int TL_RS = 4,
  parameter int TL_AW = 16
) (
  input  logic              tlm_clock_i,
  input  logic              tlm_reset_ni,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_opcode,
  input  logic [2:0]        req_param,
  input  logic [1:0]        req_size,
  input  logic [TL_AW-1:0]  req_address,
  input  logic [7:0]        req_mask,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TL_RS-1:0]  rsp_source,
  output logic [63:0]       rsp_data,
  output logic              rsp_error,
  output logic [2:0]        rsp_opcode,
  output logic [2:0]        tlm_a_opcode,
  output logic [2:0]        tlm_a_param,
  output logic [3:0]        tlm_a_size,
  output logic [TL_RS-1:0]  tlm_a_source,
  output logic [TL_AW-1:0]  tlm_a_address,
  output logic [7:0]        tlm_a_mask,
  output logic [63:0]       tlm_a_data,
  output logic              tlm_a_corrupt,
  output logic              tlm_a_valid,
  input  logic              tlm_a_ready,
  input  logic [2:0]        tlm_d_opcode,
  input  logic [1:0]        tlm_d_param,
  input  logic [3:0]        tlm_d_size,
  input  logic [TL_RS-1:0]  tlm_d_source,
  input  logic              tlm_d_denied,
  input  logic [63:0]       tlm_d_data,
  input  logic              tlm_d_corrupt,
  input  logic              tlm_d_valid,
  output logic              tlm_d_ready,
  output logic [TL_RS:0]    outstanding_o,
  output logic              unexpected_d_o
);
  localparam int NSRC = 1 << TL_RS;

  logic [NSRC-1:0] busy_q;
  logic [1:0]      meta_size_q [NSRC];
  logic [2:0]      meta_off_q  [NSRC];

  logic             free_found;
  logic [TL_RS-1:0] free_id;
  logic [TL_RS:0]   busy_cnt;
  logic             req_fire, d_fire, d_known;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_id    = TL_RS'(i);
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NSRC; i++) busy_cnt = busy_cnt + (TL_RS+1)'(busy_q[i]);
  end

  assign outstanding_o = busy_cnt;
  assign req_ready     = (~tlm_a_valid | tlm_a_ready) & free_found;
  assign req_fire      = req_valid & req_ready;
  assign tlm_d_ready   = ~rsp_valid | rsp_ready;
  assign d_fire        = tlm_d_valid & tlm_d_ready;
  assign d_known       = busy_q[tlm_d_source];
  assign tlm_a_corrupt = 1'b0;

  // A-channel payload derived from the core request
  logic [TL_AW-1:0] addr_al;
  logic [7:0]       gen_mask, a_mask_nxt;
  logic [63:0]      a_data_nxt;
  logic [2:0]       a_param_nxt;

  always_comb begin
    addr_al  = req_address;
    gen_mask = 8'hFF;
    a_data_nxt = req_wdata;
    case (req_size)
      2'd0: begin
        gen_mask   = 8'h01 << req_address[2:0];
        a_data_nxt = {8{req_wdata[7:0]}};
      end
      2'd1: begin
        addr_al[0] = 1'b0;
        gen_mask   = 8'h03 << {req_address[2:1], 1'b0};
        a_data_nxt = {4{req_wdata[15:0]}};
      end
      2'd2: begin
        addr_al[1:0] = 2'b00;
        gen_mask     = 8'h0F << {req_address[2], 2'b00};
        a_data_nxt   = {2{req_wdata[31:0]}};
      end
      default: addr_al[2:0] = 3'b000;
    endcase
    a_mask_nxt  = (req_opcode == 3'd1) ? (gen_mask & req_mask) : gen_mask;
    a_param_nxt = (req_opcode == 3'd2 || req_opcode == 3'd3) ? req_param : 3'd0;
  end

  // Response lane extraction uses the size/offset recorded when the request was issued
  logic [63:0] d_shifted, rsp_data_nxt;

  always_comb begin
    d_shifted = tlm_d_data >> {meta_off_q[tlm_d_source], 3'b000};
    case (meta_size_q[tlm_d_source])
      2'd0:    rsp_data_nxt = {56'b0, d_shifted[7:0]};
      2'd1:    rsp_data_nxt = {48'b0, d_shifted[15:0]};
      2'd2:    rsp_data_nxt = {32'b0, d_shifted[31:0]};
      default: rsp_data_nxt = d_shifted;
    endcase
    if (tlm_d_opcode == 3'd0) rsp_data_nxt = '0;
  end

  logic [5:0] unused_d;
  assign unused_d = {tlm_d_param, tlm_d_size};

  always_ff @(posedge tlm_clock_i or negedge tlm_reset_ni) begin
    if (!tlm_reset_ni) begin
      busy_q         <= '0;
      for (int i = 0; i < NSRC; i++) begin
        meta_size_q[i] <= '0;
        meta_off_q[i]  <= '0;
      end
      tlm_a_valid    <= 1'b0;
      tlm_a_opcode   <= '0;
      tlm_a_param    <= '0;
      tlm_a_size     <= '0;
      tlm_a_source   <= '0;
      tlm_a_address  <= '0;
      tlm_a_mask     <= '0;
      tlm_a_data     <= '0;
      rsp_valid      <= 1'b0;
      rsp_source     <= '0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
      rsp_opcode     <= '0;
      unexpected_d_o <= 1'b0;
    end else begin
      if (tlm_a_ready) tlm_a_valid <= 1'b0;
      if (req_fire) begin
        tlm_a_valid     <= 1'b1;
        tlm_a_opcode    <= req_opcode;
        tlm_a_param     <= a_param_nxt;
        tlm_a_size      <= {2'b00, req_size};
        tlm_a_source    <= free_id;
        tlm_a_address   <= addr_al;
        tlm_a_mask      <= a_mask_nxt;
        tlm_a_data      <= a_data_nxt;
        busy_q[free_id]      <= 1'b1;
        meta_size_q[free_id] <= req_size;
        meta_off_q[free_id]  <= addr_al[2:0];
      end

      if (rsp_ready) rsp_valid <= 1'b0;
      if (d_fire) begin
        if (d_known) begin
          busy_q[tlm_d_source] <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_source <= tlm_d_source;
          rsp_opcode <= tlm_d_opcode;
          rsp_error  <= tlm_d_denied | tlm_d_corrupt;
          rsp_data   <= rsp_data_nxt;
        end else begin
          unexpected_d_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tl_ul_initiator.sv
// Bench for tl_ul_initiator: directed scenarios plus randomized traffic against a byte-lane reference model.
module tb_tl_ul_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_opcode = '0, req_param = '0;
  logic [1:0]  req_size = '0;
  logic [15:0] req_address = '0;
  logic [7:0]  req_mask = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [3:0]  rsp_source;
  logic [63:0] rsp_data;
  logic [2:0]  rsp_opcode;
  logic [2:0]  tlm_a_opcode, tlm_a_param;
  logic [3:0]  tlm_a_size, tlm_a_source;
  logic [15:0] tlm_a_address;
  logic [7:0]  tlm_a_mask;
  logic [63:0] tlm_a_data;
  logic        tlm_a_corrupt, tlm_a_valid, tlm_a_ready = 1'b1;
  logic [2:0]  tlm_d_opcode = '0;
  logic [1:0]  tlm_d_param = '0;
  logic [3:0]  tlm_d_size = '0, tlm_d_source = '0;
  logic        tlm_d_denied = 1'b0, tlm_d_corrupt = 1'b0, tlm_d_valid = 1'b0, tlm_d_ready;
  logic [63:0] tlm_d_data = '0;
  logic [4:0]  outstanding_o;
  logic        unexpected_d_o;

  tl_ul_initiator #(.TL_RS(4), .TL_AW(16)) dut (
    .tlm_clock_i(clk), .tlm_reset_ni(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_param(req_param),
    .req_size(req_size), .req_address(req_address), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_opcode(rsp_opcode),
    .tlm_a_opcode(tlm_a_opcode), .tlm_a_param(tlm_a_param), .tlm_a_size(tlm_a_size),
    .tlm_a_source(tlm_a_source), .tlm_a_address(tlm_a_address), .tlm_a_mask(tlm_a_mask),
    .tlm_a_data(tlm_a_data), .tlm_a_corrupt(tlm_a_corrupt), .tlm_a_valid(tlm_a_valid),
    .tlm_a_ready(tlm_a_ready),
    .tlm_d_opcode(tlm_d_opcode), .tlm_d_param(tlm_d_param), .tlm_d_size(tlm_d_size),
    .tlm_d_source(tlm_d_source), .tlm_d_denied(tlm_d_denied), .tlm_d_data(tlm_d_data),
    .tlm_d_corrupt(tlm_d_corrupt), .tlm_d_valid(tlm_d_valid), .tlm_d_ready(tlm_d_ready),
    .outstanding_o(outstanding_o), .unexpected_d_o(unexpected_d_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit mdl_busy [16];
  int mdl_size [16];
  int mdl_off  [16];
  int mdl_op   [16];

  logic [2:0]  ea_opcode, ea_param;
  logic [3:0]  ea_size, ea_source;
  logic [15:0] ea_addr;
  logic [7:0]  ea_mask;
  logic [63:0] ea_data;
  logic [3:0]  er_source;
  logic [2:0]  er_opcode;
  logic        er_error;
  logic [63:0] er_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mdl_free();
    for (int i = 0; i < 16; i++) if (!mdl_busy[i]) return i;
    return -1;
  endfunction

  function automatic int mdl_count();
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(mdl_busy[i]);
    return c;
  endfunction

  function automatic logic [7:0] f_mask(int op, int sz, logic [15:0] addr, logic [7:0] um);
    int nb, off;
    logic [7:0] m;
    nb = 1 << sz;
    off = (int'(addr) % 8) / nb * nb;
    m = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) m[i] = 1'b1;
    if (op == 1) m = m & um;
    return m;
  endfunction

  function automatic logic [63:0] f_data(int sz, logic [63:0] wd);
    int nb;
    logic [63:0] d;
    nb = 1 << sz;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
    return d;
  endfunction

  function automatic logic [63:0] f_rsp(int op, int sz, int off, logic [63:0] d);
    logic [63:0] r;
    r = '0;
    if (op == 0) return r;
    for (int i = 0; i < (1 << sz); i++) r[8*i +: 8] = d[8*(off + i) +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_a(input string tag);
    check_val({tag, "_a_valid"},   tlm_a_valid,   1);
    check_val({tag, "_a_opcode"},  tlm_a_opcode,  ea_opcode);
    check_val({tag, "_a_param"},   tlm_a_param,   ea_param);
    check_val({tag, "_a_size"},    tlm_a_size,    ea_size);
    check_val({tag, "_a_source"},  tlm_a_source,  ea_source);
    check_val({tag, "_a_address"}, tlm_a_address, ea_addr);
    check_val({tag, "_a_mask"},    tlm_a_mask,    ea_mask);
    check_val({tag, "_a_data"},    tlm_a_data,    ea_data);
    check_val({tag, "_a_corrupt"}, tlm_a_corrupt, 0);
  endtask

  task automatic check_rsp(input string tag);
    check_val({tag, "_rsp_valid"},  rsp_valid,  1);
    check_val({tag, "_rsp_source"}, rsp_source, er_source);
    check_val({tag, "_rsp_opcode"}, rsp_opcode, er_opcode);
    check_val({tag, "_rsp_error"},  rsp_error,  er_error);
    check_val({tag, "_rsp_data"},   rsp_data,   er_data);
  endtask

  task automatic issue(input int op, input int sz, input logic [15:0] addr,
                       input logic [7:0] um, input logic [63:0] wd, input logic [2:0] prm);
    int src, nb;
    src = mdl_free();
    nb  = 1 << sz;
    req_valid = 1'b1; req_opcode = op[2:0]; req_size = sz[1:0]; req_address = addr;
    req_mask = um; req_wdata = wd; req_param = prm;
    #1;
    check_val("issue_req_ready", req_ready, src >= 0);
    step();
    req_valid = 1'b0;
    ea_opcode = op[2:0];
    ea_param  = (op == 2 || op == 3) ? prm : 3'd0;
    ea_size   = 4'(sz);
    ea_source = 4'(src);
    ea_addr   = 16'((int'(addr) / nb) * nb);
    ea_mask   = f_mask(op, sz, addr, um);
    ea_data   = f_data(sz, wd);
    if (src >= 0) begin
      mdl_busy[src] = 1'b1;
      mdl_size[src] = sz;
      mdl_off[src]  = (int'(addr) % 8) / nb * nb;
      mdl_op[src]   = op;
    end
    check_a("issue");
    check_val("issue_outstanding", outstanding_o, mdl_count());
  endtask

  task automatic d_beat(input int src, input int op, input logic [63:0] d,
                        input bit den, input bit cor);
    bit known;
    known = mdl_busy[src];
    tlm_d_valid = 1'b1; tlm_d_source = src[3:0]; tlm_d_opcode = op[2:0];
    tlm_d_data = d; tlm_d_denied = den; tlm_d_corrupt = cor;
    tlm_d_size = 4'(mdl_size[src]);
    #1;
    if (rsp_ready) check_val("d_ready", tlm_d_ready, 1);
    if (tlm_a_ready && !req_valid) check_val("d_pre_req_ready", req_ready, mdl_free() >= 0);
    step();
    tlm_d_valid = 1'b0;
    if (known) begin
      er_source = src[3:0];
      er_opcode = op[2:0];
      er_error  = den | cor;
      er_data   = f_rsp(op, mdl_size[src], mdl_off[src], d);
      mdl_busy[src] = 1'b0;
      check_rsp("d");
    end else begin
      check_val("unexp_no_rsp", rsp_valid, 0);
      check_val("unexp_flag", unexpected_d_o, 1);
    end
    check_val("d_outstanding", outstanding_o, mdl_count());
  endtask

  task automatic drain();
    for (int s = 0; s < 16; s++)
      if (mdl_busy[s]) d_beat(s, (mdl_op[s] >= 2) ? 1 : 0, {$urandom, $urandom}, 1'b0, 1'b0);
  endtask

  initial begin
    int src, op, sz;
    logic [63:0] rnd;
    for (int i = 0; i < 16; i++) mdl_busy[i] = 1'b0;

    #12;
    check_val("rst_a_valid", tlm_a_valid, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_outstanding", outstanding_o, 0);
    check_val("rst_unexpected", unexpected_d_o, 0);
    check_val("rst_a_data", tlm_a_data, 0);
    rst_n = 1'b1;
    step();
    check_val("idle_req_ready", req_ready, 1);

    // byte put with lane replication
    issue(0, 0, 16'h0005, 8'h00, 64'hAB, 3'd0);
    check_val("byte_put_source", tlm_a_source, 0);
    check_val("byte_put_mask", tlm_a_mask, 8'h20);
    check_val("byte_put_data", tlm_a_data, 64'hABABABABABABABAB);
    d_beat(0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
    check_val("byte_put_rsp_data", rsp_data, 0);
    check_val("byte_put_rsp_err", rsp_error, 0);

    // halfword get at byte offset 6
    issue(4, 1, 16'h0016, 8'h00, 64'h0, 3'd5);
    check_val("hw_get_mask", tlm_a_mask, 8'hC0);
    check_val("hw_get_addr", tlm_a_address, 16'h0016);
    d_beat(0, 1, 64'h1122334455667788, 1'b0, 1'b0);
    check_val("hw_get_rsp_data", rsp_data, 64'h1122);

    // fill all sources, then free one under a full table
    for (int i = 0; i < 16; i++) begin
      issue(0, 3, 16'(i * 8), 8'h00, {$urandom, $urandom}, 3'd0);
      check_val("fill_source", tlm_a_source, i);
    end
    req_valid = 1'b1;
    #1;
    check_val("full_req_ready", req_ready, 0);
    check_val("full_outstanding", outstanding_o, 16);
    req_valid = 1'b0;
    d_beat(7, 0, 64'h0, 1'b1, 1'b0);
    check_val("free7_err", rsp_error, 1);
    issue(4, 2, 16'h0104, 8'h00, 64'h0, 3'd0);
    check_val("realloc_source", tlm_a_source, 7);
    drain();

    // A-channel backpressure
    step();
    tlm_a_ready = 1'b0;
    issue(3, 2, 16'h0a4c, 8'h00, 64'h0123456789abcdef, 3'd6);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_opcode = 3'd0; req_address = 16'h1111; req_wdata = '1;
      #1;
      check_val("a_stall_req_ready", req_ready, 0);
      step();
      check_a("a_stall");
    end
    req_valid = 1'b0;
    tlm_a_ready = 1'b1;
    step();
    check_val("a_release_valid", tlm_a_valid, 0);

    // response backpressure; the presented unknown beat must not be consumed
    rsp_ready = 1'b0;
    d_beat(0, 1, 64'hFEDCBA9876543210, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tlm_d_valid = 1'b1; tlm_d_source = 4'd9; tlm_d_data = '0; tlm_d_opcode = 3'd1;
      #1;
      check_val("rsp_stall_d_ready", tlm_d_ready, 0);
      step();
      check_rsp("rsp_stall");
    end
    tlm_d_valid = 1'b0;
    check_val("rsp_stall_no_unexp", unexpected_d_o, 0);
    rsp_ready = 1'b1;
    step();
    check_val("rsp_release_valid", rsp_valid, 0);

    // unexpected D beat is dropped and the flag sticks
    d_beat(3, 1, 64'h55, 1'b0, 1'b0);
    repeat (3) step();
    check_val("unexp_sticky", unexpected_d_o, 1);
    check_val("unexp_outstanding", outstanding_o, 0);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      if (mdl_free() >= 0 && (mdl_count() == 0 || $urandom_range(0, 1) == 1)) begin
        op = $urandom_range(0, 4);
        sz = $urandom_range(0, 3);
        issue(op, sz, 16'($urandom), 8'($urandom), {$urandom, $urandom}, 3'($urandom));
      end else begin
        src = $urandom_range(0, 15);
        while (!mdl_busy[src]) src = (src + 1) % 16;
        rnd = {$urandom, $urandom};
        d_beat(src, (mdl_op[src] >= 2) ? 1 : 0, rnd,
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end
    drain();

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) issue(4, 0, 16'(i), 8'h00, 64'h0, 3'd0);
    step();
    tlm_a_ready = 1'b0;
    issue(0, 1, 16'h0020, 8'h00, 64'h77, 3'd0);
    rsp_ready = 1'b0;
    d_beat(1, 1, 64'h12345678, 1'b0, 1'b0);
    check_val("pre_rst_outstanding", outstanding_o, 4);
    #3 rst_n = 1'b0;
    #1;
    check_val("mid_rst_a_valid", tlm_a_valid, 0);
    check_val("mid_rst_rsp_valid", rsp_valid, 0);
    check_val("mid_rst_outstanding", outstanding_o, 0);
    check_val("mid_rst_unexpected", unexpected_d_o, 0);
    check_val("mid_rst_a_addr", tlm_a_address, 0);
    check_val("mid_rst_a_mask", tlm_a_mask, 0);
    check_val("mid_rst_rsp_data", rsp_data, 0);
    for (int i = 0; i < 16; i++) mdl_busy[i] = 1'b0;
    tlm_a_ready = 1'b1;
    rsp_ready = 1'b1;
    #10 rst_n = 1'b1;
    step();
    d_beat(0, 1, 64'h99, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
